gps_frame_reader: RTL and testbench
===================================

Name: gps_frame_reader

Overview:
- Parametrised successor to the fixed five-output GPS controller.
- Starts a frame read on a data-ready edge, drives a byte-serial bus master (ena/busy/data_rd) and checks a two-byte sync header.
- Assembles NUM_FIELDS big-endian fields of configurable width, verifies an 8-bit additive checksum and publishes all fields atomically.
- Sits between the I2C byte master and the navigation datapath.

Parameters:
- FIELD_W, 20, width of each published field (1..BYTES_PER_FIELD*8)
- NUM_FIELDS, 5, fields per frame (x, y, z, time, ground_speed by default)
- BYTES_PER_FIELD, 3, payload bytes per field, MSB first
- SYNC0, 8'hB5, first header byte
- SYNC1, 8'h62, second header byte
- REG_ADDR, 8'h00, register address presented on data_wr
- TIMEOUT, 4096, max cycles waiting for any busy edge

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- new  in  1  GPS data-ready, synchronous to clk; rising edge requests a frame
- busy  in  1  byte master busy
- data_rd  in  8  byte from master, valid in the cycle busy falls
- ena  out  1  transaction request to master
- data_wr  out  8  constant REG_ADDR
- fields  out  NUM_FIELDS*FIELD_W  published fields, field 0 in LSBs
- frame_valid  out  1  one-cycle pulse when fields update
- cksum_err  out  1  one-cycle pulse on checksum mismatch
- sync_err  out  1  one-cycle pulse on header mismatch
- timeout_err  out  1  one-cycle pulse on bus timeout
- frame_count  out  16  count of good frames, wraps at 0xFFFF->0

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, pending flag 0, counters 0. data_wr is the constant REG_ADDR at all times.
- FRAME_BYTES = 2 + NUM_FIELDS*BYTES_PER_FIELD + 1.
- Byte handshake:
  - A busy 0->1 edge means the master accepted a byte request.
  - A busy 1->0 edge means the byte completed; data_rd is sampled in that cycle.
  - ena stays high until the busy rise for byte FRAME_BYTES-1, then drops in the next cycle.
  - Two counters: accepted (busy rises) and completed (busy falls).
- States:
  - IDLE -> REQ on a new rising edge or on pending=1; clears pending.
  - REQ: ena=1.
  - HDR0: byte must equal SYNC0.
  - HDR1: byte must equal SYNC1.
  - PAYLOAD: shift bytes into the staging register and accumulate sum mod 256.
  - CKSUM: compare the received byte with the sum.
  - PUBLISH: one cycle, then IDLE.
  - ABORT: drop ena, wait for busy=0, then IDLE.
- Header mismatch: pulse sync_err in the cycle after the falling edge, go to ABORT; fields unchanged.
- Checksum mismatch: pulse cksum_err, go to IDLE; fields and frame_count unchanged.
- Checksum match: in PUBLISH, for each field k, fields slice k gets the low FIELD_W bits of payload bytes k*BPF..k*BPF+BPF-1; frame_valid=1 and frame_count+1 in the same cycle. Latency is 1 cycle from the checksum byte's busy fall.
- Checksum covers payload bytes only; header bytes are excluded.
- Timeout: the cycle counter resets on every busy edge. When it reaches TIMEOUT in any non-IDLE state, pulse timeout_err and go to ABORT.
- A new rising edge while not IDLE sets pending (one deep; further edges are lost). Pending starts the next frame directly from IDLE with no gap cycle.
- A new edge in the PUBLISH cycle sets pending.
- fields never shows a partial frame.

Decomposition:
- Package gps_pkg:
  - state enum localparams
  - FRAME_BYTES and the default SYNC constants
  - helper function: field index to byte offset
- Sub-module gps_field_unpack: combinational slicing of the staging register into the fields bus, parametrised by NUM_FIELDS, BYTES_PER_FIELD, FIELD_W.
- A byte-master behavioural model lives in the bench only.

Test Plan:
Defaults apply unless stated.
- Good frame: B5 62, fifteen 0x01 payload bytes, checksum 0x0F -> each field = 20'h10101, frame_valid pulses once, frame_count=1, ena low after byte 18 accepted.
- Truncation: field 0 bytes 0xAB 0xCD 0xEF, other payload bytes 0x00, checksum 0x67 -> field0 = 20'hBCDEF, all other fields 0.
- Bad checksum: good frame with checksum 0x10 -> cksum_err pulse, fields and frame_count unchanged.
- Bad sync: first byte 0xB4 -> sync_err pulse, ena drops, no payload bytes requested.
- Stall: the master holds busy high for 5000 cycles -> timeout_err at cycle 4096, ABORT, then IDLE once busy=0.
- Back-to-back:
  - new pulses twice during a frame -> exactly one follow-on frame starts the cycle after PUBLISH.
  - rst=0 mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/gps_pkg.sv
// rtl/gps_pkg.sv - shared states, frame constants and helpers for the GPS frame reader
package gps_pkg;

    // Frame reader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CKSUM,
        ST_PUBLISH,
        ST_ABORT
    } gps_state_t;

    // Default frame geometry: x, y, z, time, ground_speed as 3-byte fields
    localparam int         DEF_FIELD_W         = 20;
    localparam int         DEF_NUM_FIELDS      = 5;
    localparam int         DEF_BYTES_PER_FIELD = 3;
    localparam logic [7:0] DEF_SYNC0           = 8'hB5;
    localparam logic [7:0] DEF_SYNC1           = 8'h62;
    localparam logic [7:0] DEF_REG_ADDR        = 8'h00;
    localparam int         DEF_TIMEOUT         = 4096;

    // Two sync bytes, the payload, and one trailing checksum byte
    function automatic int frame_bytes(input int num_fields, input int bytes_per_field);
        return 2 + num_fields * bytes_per_field + 1;
    endfunction

    localparam int DEF_FRAME_BYTES = frame_bytes(DEF_NUM_FIELDS, DEF_BYTES_PER_FIELD);

    // Payload byte index of the most significant byte of a field
    function automatic int field_byte_offset(input int field_idx, input int bytes_per_field);
        return field_idx * bytes_per_field;
    endfunction

endpackage

// File: rtl/gps_field_unpack.sv
// rtl/gps_field_unpack.sv - slices the payload staging register into the fields bus
module gps_field_unpack
    import gps_pkg::*;
#(
    parameter int NUM_FIELDS      = DEF_NUM_FIELDS,
    parameter int BYTES_PER_FIELD = DEF_BYTES_PER_FIELD,
    parameter int FIELD_W         = DEF_FIELD_W
) (
    input  logic [NUM_FIELDS*BYTES_PER_FIELD*8-1:0] staging,
    output logic [NUM_FIELDS*FIELD_W-1:0]           fields
);

    localparam int PAYLOAD_BYTES = NUM_FIELDS * BYTES_PER_FIELD;
    localparam int CHUNK_W       = BYTES_PER_FIELD * 8;

    // The first payload byte sits in the top byte of staging, so field k's
    // big-endian chunk starts (PAYLOAD_BYTES - offset) bytes from the bottom.
    for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
        localparam int HI = (PAYLOAD_BYTES - field_byte_offset(k, BYTES_PER_FIELD)) * 8 - 1;
        localparam int LO = HI - CHUNK_W + 1;

        assign fields[k*FIELD_W +: FIELD_W] = staging[LO +: FIELD_W];

        // High-order chunk bits beyond FIELD_W are deliberately discarded
        if (FIELD_W < CHUNK_W) begin : g_trunc
            logic unused_high_bits;
            assign unused_high_bits = ^staging[HI -: (CHUNK_W - FIELD_W)];
        end
    end

endmodule

// File: rtl/gps_frame_reader.sv
// rtl/gps_frame_reader.sv - reads, verifies and atomically publishes GPS frames from a byte master
module gps_frame_reader
    import gps_pkg::*;
#(
    parameter int         FIELD_W         = DEF_FIELD_W,
    parameter int         NUM_FIELDS      = DEF_NUM_FIELDS,
    parameter int         BYTES_PER_FIELD = DEF_BYTES_PER_FIELD,
    parameter logic [7:0] SYNC0           = DEF_SYNC0,
    parameter logic [7:0] SYNC1           = DEF_SYNC1,
    parameter logic [7:0] REG_ADDR        = DEF_REG_ADDR,
    parameter int         TIMEOUT         = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          new_data,
    input  logic                          busy,
    input  logic [7:0]                    data_rd,
    output logic                          ena,
    output logic [7:0]                    data_wr,
    output logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic                          frame_valid,
    output logic                          cksum_err,
    output logic                          sync_err,
    output logic                          timeout_err,
    output logic [15:0]                   frame_count
);

    localparam int PAYLOAD_BYTES = NUM_FIELDS * BYTES_PER_FIELD;
    localparam int STAGE_W       = PAYLOAD_BYTES * 8;
    localparam int FRAME_BYTES   = frame_bytes(NUM_FIELDS, BYTES_PER_FIELD);
    localparam int CNT_W         = $clog2(FRAME_BYTES + 1);
    localparam int TMR_W         = $clog2(TIMEOUT + 1);

    // Rise index of the checksum byte: ena is withdrawn once it is accepted
    localparam logic [CNT_W-1:0] LAST_ACCEPT  = CNT_W'(FRAME_BYTES - 1);
    // Fall index of the final payload byte
    localparam logic [CNT_W-1:0] LAST_PAYLOAD = CNT_W'(FRAME_BYTES - 2);
    localparam logic [TMR_W-1:0] TMR_LIMIT    = TMR_W'(TIMEOUT - 1);

    gps_state_t           state;
    logic                 pending;
    logic                 new_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     accepted;
    logic [CNT_W-1:0]     completed;
    logic [TMR_W-1:0]     timer;
    logic [7:0]           sum;
    logic [STAGE_W-1:0]   staging;
    logic [NUM_FIELDS*FIELD_W-1:0] unpacked;

    logic new_rise;
    logic busy_rise;
    logic busy_fall;
    logic busy_edge;

    assign data_wr   = REG_ADDR;
    assign new_rise  = new_data & ~new_q;
    assign busy_rise = busy & ~busy_q;
    assign busy_fall = ~busy & busy_q;
    assign busy_edge = busy ^ busy_q;

    gps_field_unpack #(
        .NUM_FIELDS      (NUM_FIELDS),
        .BYTES_PER_FIELD (BYTES_PER_FIELD),
        .FIELD_W         (FIELD_W)
    ) u_unpack (
        .staging (staging),
        .fields  (unpacked)
    );

    // Delay the data-ready and busy inputs by one cycle for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            new_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            new_q  <= new_data;
            busy_q <= busy;
        end
    end

    // Frame sequencer: byte handshake bookkeeping, header/checksum checks, publish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            ena         <= 1'b0;
            accepted    <= '0;
            completed   <= '0;
            timer       <= '0;
            sum         <= '0;
            staging     <= '0;
            fields      <= '0;
            frame_valid <= 1'b0;
            cksum_err   <= 1'b0;
            sync_err    <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            cksum_err   <= 1'b0;
            sync_err    <= 1'b0;
            timeout_err <= 1'b0;

            if (busy_rise) begin
                accepted <= accepted + CNT_W'(1);
            end
            if (busy_fall) begin
                completed <= completed + CNT_W'(1);
            end

            // Watchdog restarts on any bus activity and sleeps while idle
            if (busy_edge || state == ST_IDLE) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end

            // A data-ready edge during a frame is remembered once; later ones are lost
            if (new_rise && state != ST_IDLE) begin
                pending <= 1'b1;
            end

            if (ena && busy_rise && accepted == LAST_ACCEPT) begin
                ena <= 1'b0;
            end

            if (state != ST_IDLE && !busy_edge && timer == TMR_LIMIT) begin
                timeout_err <= 1'b1;
                ena         <= 1'b0;
                timer       <= '0;
                state       <= ST_ABORT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (new_rise || pending) begin
                            pending   <= 1'b0;
                            ena       <= 1'b1;
                            accepted  <= '0;
                            completed <= '0;
                            sum       <= '0;
                            state     <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        state <= ST_HDR0;
                    end
                    ST_HDR0: begin
                        if (busy_fall) begin
                            if (data_rd == SYNC0) begin
                                state <= ST_HDR1;
                            end else begin
                                sync_err <= 1'b1;
                                ena      <= 1'b0;
                                state    <= ST_ABORT;
                            end
                        end
                    end
                    ST_HDR1: begin
                        if (busy_fall) begin
                            if (data_rd == SYNC1) begin
                                state <= ST_PAYLOAD;
                            end else begin
                                sync_err <= 1'b1;
                                ena      <= 1'b0;
                                state    <= ST_ABORT;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (busy_fall) begin
                            staging <= {staging[STAGE_W-9:0], data_rd};
                            sum     <= sum + data_rd;
                            if (completed == LAST_PAYLOAD) begin
                                state <= ST_CKSUM;
                            end
                        end
                    end
                    ST_CKSUM: begin
                        if (busy_fall) begin
                            ena <= 1'b0;
                            if (data_rd == sum) begin
                                // Fields, pulse and count all change together in PUBLISH
                                fields      <= unpacked;
                                frame_valid <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                                state       <= ST_PUBLISH;
                            end else begin
                                cksum_err <= 1'b1;
                                state     <= ST_IDLE;
                            end
                        end
                    end
                    ST_PUBLISH: begin
                        state <= ST_IDLE;
                    end
                    ST_ABORT: begin
                        if (!busy) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        ena   <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gps_frame_reader.sv
// tb/tb_gps_frame_reader.sv - table-driven scoreboard bench for gps_frame_reader
module tb_gps_frame_reader;
    import gps_pkg::*;

    localparam int FW  = 20;
    localparam int NF  = 5;
    localparam int BPF = 3;
    localparam int TMO = 4096;
    localparam int FB  = DEF_FRAME_BYTES;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              new_data = 1'b0;
    logic              busy     = 1'b0;
    logic [7:0]        data_rd  = 8'h00;
    logic              ena;
    logic [7:0]        data_wr;
    logic [NF*FW-1:0]  fields;
    logic              frame_valid;
    logic              cksum_err;
    logic              sync_err;
    logic              timeout_err;
    logic [15:0]       frame_count;

    always #5 clk = ~clk;

    gps_frame_reader #(
        .FIELD_W         (FW),
        .NUM_FIELDS      (NF),
        .BYTES_PER_FIELD (BPF),
        .SYNC0           (8'hB5),
        .SYNC1           (8'h62),
        .REG_ADDR        (8'h00),
        .TIMEOUT         (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .new_data    (new_data),
        .busy        (busy),
        .data_rd     (data_rd),
        .ena         (ena),
        .data_wr     (data_wr),
        .fields      (fields),
        .frame_valid (frame_valid),
        .cksum_err   (cksum_err),
        .sync_err    (sync_err),
        .timeout_err (timeout_err),
        .frame_count (frame_count)
    );

    // kind: 1 good frame, 2 checksum error, 3 sync error, 4 timeout
    typedef struct {
        string            name;
        logic [7:0]       s0;
        logic [7:0]       s1;
        logic [7:0]       b0;
        logic [7:0]       b1;
        logic [7:0]       b2;
        logic [7:0]       fill;
        logic [7:0]       ck;
        int               kind;
        int               nbytes;
        logic [NF*FW-1:0] fields;
    } vec_t;

    typedef struct {
        int               kind;
        logic [NF*FW-1:0] fields;
        logic [15:0]      count;
    } exp_t;

    exp_t             sb_q[$];
    vec_t             vecs[7];
    logic [7:0]       fb[0:31];
    logic [NF*FW-1:0] model_fields = '0;
    logic [15:0]      model_count  = '0;
    int               pass_cnt     = 0;
    int               check_cnt    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic [7:0] s0, input logic [7:0] s1,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] fill, input logic [7:0] ck, input int kind,
                                input int nbytes, input logic [NF*FW-1:0] f);
        vec_t v;
        v.name = n; v.s0 = s0; v.s1 = s1; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.fill = fill; v.ck = ck; v.kind = kind; v.nbytes = nbytes; v.fields = f;
        return v;
    endfunction

    task automatic pulse_new();
        new_data = 1'b1;
        @(posedge clk); #1;
        new_data = 1'b0;
    endtask

    // Byte master model: serves one byte per ena, stops when ena stays low
    task automatic serve(input int nb, input int hold, output int served);
        int w;
        served = 0;
        for (int i = 0; i < nb; i++) begin
            w = 0;
            while (ena !== 1'b1 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (ena !== 1'b1) break;
            busy = 1'b1;
            repeat (hold) @(posedge clk);
            #1;
            busy    = 1'b0;
            data_rd = fb[i];
            served++;
            @(posedge clk); #1;
        end
    endtask

    task automatic load_frame(input vec_t v);
        fb[0] = v.s0;
        fb[1] = v.s1;
        for (int i = 0; i < NF * BPF; i++)
            fb[2+i] = (i == 0) ? v.b0 : (i == 1) ? v.b1 : (i == 2) ? v.b2 : v.fill;
        fb[FB-1] = v.ck;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        if (v.kind == 1) begin
            model_fields = v.fields;
            model_count  = model_count + 16'd1;
        end
        e.kind = v.kind; e.fields = model_fields; e.count = model_count;
        sb_q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        int served;
        int w;
        load_frame(v);
        push_exp(v);
        pulse_new();
        serve(FB + 2, hold, served);
        check({v.name, "_bytes"}, 128'(served), 128'(v.nbytes));
        w = 0;
        while (sb_q.size() != 0 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check({v.name, "_event_seen"}, 128'(sb_q.size()), 128'(0));
        check({v.name, "_ena_idle"}, 128'(ena), 128'(0));
    endtask

    // Scoreboard monitor: every status pulse pops one expectation
    always @(negedge clk) begin
        int   ak;
        exp_t e;
        if (rst && (frame_valid || cksum_err || sync_err || timeout_err)) begin
            ak = frame_valid ? 1 : (cksum_err ? 2 : (sync_err ? 3 : 4));
            if (sb_q.size() == 0) begin
                check_cnt++;
                $display("FAIL unexpected_event: got kind %0d, expected none", ak);
            end else begin
                e = sb_q.pop_front();
                check("event_kind", 128'(ak), 128'(e.kind));
                check("event_fields", 128'(fields), 128'(e.fields));
                check("event_count", 128'(frame_count), 128'(e.count));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   served;
        int   n;
        int   extra;
        int   hi_cnt;
        exp_t e;

        for (int i = 0; i < 32; i++) fb[i] = 8'h00;
        vecs[0] = mk("good_ones", 8'hB5, 8'h62, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0F, 1, 18, {5{20'h10101}});
        vecs[1] = mk("truncate",  8'hB5, 8'h62, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h67, 1, 18, 100'hBCDEF);
        vecs[2] = mk("bad_cksum", 8'hB5, 8'h62, 8'h01, 8'h01, 8'h01, 8'h01, 8'h10, 2, 18, '0);
        vecs[3] = mk("bad_sync0", 8'hB4, 8'h62, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0F, 3, 1, '0);
        vecs[4] = mk("bad_sync1", 8'hB5, 8'h63, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0F, 3, 2, '0);
        vecs[5] = mk("all_ones",  8'hB5, 8'h62, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF1, 1, 18, {100{1'b1}});
        vecs[6] = mk("mixed",     8'hB5, 8'h62, 8'h12, 8'h34, 8'h56, 8'h80, 8'h9C, 1, 18,
                     {{4{20'h08080}}, 20'h23456});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ena", 128'(ena), 128'(0));
        check("reset_fields", 128'(fields), 128'(0));
        check("reset_count", 128'(frame_count), 128'(0));
        check("reset_pulses", 128'({frame_valid, cksum_err, sync_err, timeout_err}), 128'(0));
        check("data_wr", 128'(data_wr), 128'(8'h00));
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], (i % 3) + 1);

        // Stall: busy held high for 5000 cycles
        e.kind = 4; e.fields = model_fields; e.count = model_count;
        sb_q.push_back(e);
        pulse_new();
        busy = 1'b1;
        n = 0;
        while (!timeout_err && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_timeout_cycle", 128'(n - 1), 128'(TMO));
        check("stall_ena_dropped", 128'(ena), 128'(0));
        extra = 0;
        while (n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (timeout_err) extra++;
        end
        check("stall_single_pulse", 128'(extra), 128'(0));
        busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_event_seen", 128'(sb_q.size()), 128'(0));
        run_vec(vecs[0], 1);

        // Back-to-back: two data-ready edges during a frame give one follow-on frame
        load_frame(vecs[0]);
        push_exp(vecs[0]);
        push_exp(vecs[0]);
        pulse_new();
        fork
            serve(FB, 2, served);
            begin
                repeat (6) @(posedge clk);
                #1;
                pulse_new();
                repeat (6) @(posedge clk);
                #1;
                pulse_new();
            end
        join
        check("b2b_first_bytes", 128'(served), 128'(FB));
        @(posedge clk); #1;
        check("b2b_idle_cycle_ena", 128'(ena), 128'(0));
        @(posedge clk); #1;
        check("b2b_restart_ena", 128'(ena), 128'(1));
        serve(FB, 1, served);
        check("b2b_second_bytes", 128'(served), 128'(FB));
        hi_cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ena) hi_cnt++;
        end
        check("b2b_no_third_frame", 128'(hi_cnt), 128'(0));
        check("b2b_events_seen", 128'(sb_q.size()), 128'(0));

        // Asynchronous reset mid-payload
        load_frame(vecs[1]);
        pulse_new();
        fork
            serve(FB, 1, served);
            begin
                repeat (12) @(posedge clk);
                #3;
                rst = 1'b0;
                #1;
                check("midrst_ena", 128'(ena), 128'(0));
                check("midrst_fields", 128'(fields), 128'(0));
                check("midrst_count", 128'(frame_count), 128'(0));
                check("midrst_pulses", 128'({frame_valid, cksum_err, sync_err, timeout_err}), 128'(0));
            end
        join
        model_fields = '0;
        model_count  = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[6], 2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
